// File: rtl/sfp_ctrl_pkg.sv
// Shared constants for the SFP back-end sequencer: state encoding and default geometry
// used by the core controller and the SFP datapath.
package sfp_ctrl_pkg;

    localparam int unsigned SFP_ROWS   = 8;
    localparam int unsigned SFP_ADDR_W = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ACCUM = 3'd1;
    localparam logic [2:0] ST_SYNC  = 3'd2;
    localparam logic [2:0] ST_DIV   = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/sfp_sync_timer.sv
// SYNC wait timer: cleared by load, counts enabled cycles, flags expire on the
// TIMEOUT-th consecutive enabled cycle. Only built with SFP_SYNC_TIMEOUT_EN.
module sfp_sync_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        expire = en && (cnt_q == CW'(TIMEOUT - 1));
        cnt_d  = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en && !expire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sfp_ctrl.sv
// SFP sequencer: OFIFO drain into the accumulator, peer partial-sum exchange, then per-row
// divide and PMEM write. Optional SYNC timeout is enabled with macro SFP_SYNC_TIMEOUT_EN.
module sfp_ctrl
    import sfp_ctrl_pkg::*;
#(
    parameter int unsigned ROWS    = SFP_ROWS,
    parameter int unsigned ADDR_W  = SFP_ADDR_W,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ofifo_valid,
    output logic              ofifo_rd,
    output logic              acc,
    output logic              sum_out_valid,
    input  logic              sum_in_valid,
    output logic              div,
    output logic [ADDR_W-1:0] sfp_row,
    output logic              pmem_wr,
    output logic [ADDR_W-1:0] pmem_add,
    output logic              busy,
    output logic              done,
    output logic              sync_timeout
);

    localparam logic [ADDR_W:0] ROWS_C = (ADDR_W + 1)'(ROWS);
    localparam logic [ADDR_W:0] LAST_C = (ADDR_W + 1)'(ROWS - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
    logic [ADDR_W:0]   row_q, row_d;
    logic              peer_seen_q, peer_seen_d;
    logic              acc_q, acc_d;
    logic [ADDR_W-1:0] sfp_row_q, sfp_row_d;
    logic [ADDR_W-1:0] pmem_add_q, pmem_add_d;
    logic              timer_expire;

    always_comb begin
        state_d       = state_q;
        rd_cnt_d      = rd_cnt_q;
        row_d         = row_q;
        peer_seen_d   = peer_seen_q;
        ofifo_rd      = 1'b0;
        sum_out_valid = 1'b0;
        div           = 1'b0;
        pmem_wr       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                rd_cnt_d    = '0;
                row_d       = '0;
                peer_seen_d = 1'b0;
                if (start) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                ofifo_rd = ofifo_valid && (rd_cnt_q < ROWS_C);
                if (ofifo_rd) rd_cnt_d = rd_cnt_q + 1'b1;
                if (sum_in_valid) peer_seen_d = 1'b1;
                // Leave only once the last read's accumulate strobe is on the output.
                if (rd_cnt_q == ROWS_C && acc_q) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                sum_out_valid = 1'b1;
                if (sum_in_valid) peer_seen_d = 1'b1;
                if (sum_in_valid || peer_seen_q || timer_expire) state_d = ST_DIV;
            end
            ST_DIV: begin
                div     = 1'b1;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                pmem_wr = 1'b1;
                if (row_q == LAST_C) begin
                    state_d = ST_DONE;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = ST_DIV;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        acc_d      = ofifo_rd;
        sfp_row_d  = (state_q == ST_DIV)   ? row_q[ADDR_W-1:0] : sfp_row_q;
        pmem_add_d = (state_q == ST_WRITE) ? row_q[ADDR_W-1:0] : pmem_add_q;
    end

    assign acc      = acc_q;
    assign sfp_row  = sfp_row_d;
    assign pmem_add = pmem_add_d;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rd_cnt_q    <= '0;
            row_q       <= '0;
            peer_seen_q <= 1'b0;
            acc_q       <= 1'b0;
            sfp_row_q   <= '0;
            pmem_add_q  <= '0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            row_q       <= row_d;
            peer_seen_q <= peer_seen_d;
            acc_q       <= acc_d;
            sfp_row_q   <= sfp_row_d;
            pmem_add_q  <= pmem_add_d;
        end
    end

`ifdef SFP_SYNC_TIMEOUT_EN
    logic sync_wait;
    logic sync_timeout_q, sync_timeout_d;

    assign sync_wait = (state_q == ST_SYNC) && !(sum_in_valid || peer_seen_q);

    sfp_sync_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_sync_timer (
        .clk   (clk),
        .reset (reset),
        .load  (state_q != ST_SYNC),
        .en    (sync_wait),
        .expire(timer_expire)
    );

    always_comb begin
        sync_timeout_d = sync_timeout_q;
        if (state_q == ST_IDLE && start) begin
            sync_timeout_d = 1'b0;
        end else if (sync_wait && timer_expire) begin
            sync_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_timeout_q <= 1'b0;
        end else begin
            sync_timeout_q <= sync_timeout_d;
        end
    end

    assign sync_timeout = sync_timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timer_expire   = 1'b0;
    assign sync_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_sfp_ctrl.sv
// Bench for sfp_ctrl: per-pass event timeline computed arithmetically from the input
// patterns, compared against the DUT every cycle, plus literal timing pins.
module tb_sfp_ctrl;

    localparam int ROWS    = 8;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 64;
    localparam int MAXC    = 256;

    logic              clk = 1'b0;
    logic              reset, start, ofifo_valid, sum_in_valid;
    logic              ofifo_rd, acc, sum_out_valid, div, pmem_wr, busy, done, sync_timeout;
    logic [ADDR_W-1:0] sfp_row, pmem_add;

    sfp_ctrl #(
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ofifo_valid  (ofifo_valid),
        .ofifo_rd     (ofifo_rd),
        .acc          (acc),
        .sum_out_valid(sum_out_valid),
        .sum_in_valid (sum_in_valid),
        .div          (div),
        .sfp_row      (sfp_row),
        .pmem_wr      (pmem_wr),
        .pmem_add     (pmem_add),
        .busy         (busy),
        .done         (done),
        .sync_timeout (sync_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ov[MAXC], siv[MAXC];
    int e_rd[MAXC], e_acc[MAXC], e_sov[MAXC], e_div[MAXC], e_row[MAXC];
    int e_wr[MAXC], e_addr[MAXC], e_busy[MAXC], e_done[MAXC], e_to[MAXC];
    int cyc = -1;
    bit check_en = 1'b0;
    int prev_row = 0, prev_addr = 0, prev_to = 0;
    int obs_rd, obs_acc, obs_sov, obs_div, obs_wr, obs_done, obs_div1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Expected timeline of one pass (start in cycle 0) from the ov/siv input patterns.
    task automatic build(input int abort_at, output int e);
        int n, last, ss, fs, to, cr, ca;
        for (int c = 0; c < MAXC; c++) begin
            e_rd[c] = 0; e_acc[c] = 0; e_sov[c] = 0; e_div[c] = 0;
            e_wr[c] = 0; e_busy[c] = 0; e_done[c] = 0;
        end
        n = 0; last = 0;
        for (int t = 1; t < MAXC - 1 && n < ROWS; t++) begin
            if (ov[t] != 0) begin
                e_rd[t] = 1; e_acc[t + 1] = 1; n++; last = t;
            end
        end
        ss = last + 2;
        fs = MAXC;
        for (int t = MAXC - 1; t >= 1; t--) if (siv[t] != 0) fs = t;
        e  = (fs > ss) ? fs : ss;
        to = 0;
`ifdef SFP_SYNC_TIMEOUT_EN
        if (e > ss + TIMEOUT - 1) begin
            e  = ss + TIMEOUT - 1;
            to = 1;
        end
`endif
        for (int t = ss; t <= e; t++) e_sov[t] = 1;
        for (int k = 0; k < ROWS; k++) begin
            e_div[e + 1 + 2 * k] = 1;
            e_wr[e + 2 + 2 * k]  = 1;
        end
        e_done[e + 2 * ROWS + 1] = 1;
        for (int t = 1; t <= e + 2 * ROWS + 1; t++) e_busy[t] = 1;
        cr = prev_row; ca = prev_addr;
        for (int c = 0; c < MAXC; c++) begin
            if (e_div[c] != 0) cr = (c - e - 1) / 2;
            if (e_wr[c] != 0)  ca = (c - e - 2) / 2;
            e_row[c]  = cr;
            e_addr[c] = ca;
            e_to[c]   = (c == 0) ? prev_to : ((c <= e) ? 0 : to);
        end
        if (abort_at >= 0) begin
            for (int c = abort_at + 1; c < MAXC; c++) begin
                e_rd[c] = 0; e_acc[c] = 0; e_sov[c] = 0; e_div[c] = 0; e_row[c] = 0;
                e_wr[c] = 0; e_addr[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_to[c] = 0;
            end
        end
    endtask

    task automatic do_pass(input int abort_at, input int abort_len);
        int e, len;
        build(abort_at, e);
        len = (abort_at >= 0) ? abort_len : e + 2 * ROWS + 3;
        obs_rd = 0; obs_acc = 0; obs_sov = 0; obs_div = 0; obs_wr = 0;
        obs_done = -1; obs_div1 = -1;
        for (int c = 0; c < len; c++) begin
            cyc          = c;
            start        = (c == 0);
            reset        = (c == abort_at);
            ofifo_valid  = (ov[c] != 0);
            sum_in_valid = (siv[c] != 0);
            check_en     = 1'b1;
            @(posedge clk);
            #1;
        end
        check_en  = 1'b0;
        prev_row  = e_row[len - 1];
        prev_addr = e_addr[len - 1];
        prev_to   = e_to[len - 1];
    endtask

    task automatic fill(input int ov_v, input int siv_v);
        for (int t = 0; t < MAXC; t++) begin
            ov[t] = ov_v; siv[t] = siv_v;
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("ofifo_rd", ofifo_rd, e_rd[cyc]);
            chk("acc", acc, e_acc[cyc]);
            chk("sum_out_valid", sum_out_valid, e_sov[cyc]);
            chk("div", div, e_div[cyc]);
            chk("sfp_row", sfp_row, e_row[cyc]);
            chk("pmem_wr", pmem_wr, e_wr[cyc]);
            chk("pmem_add", pmem_add, e_addr[cyc]);
            chk("busy", busy, e_busy[cyc]);
            chk("done", done, e_done[cyc]);
            chk("sync_timeout", sync_timeout, e_to[cyc]);
            if (ofifo_rd === 1'b1) obs_rd++;
            if (acc === 1'b1) obs_acc++;
            if (sum_out_valid === 1'b1) obs_sov++;
            if (pmem_wr === 1'b1) obs_wr++;
            if (div === 1'b1) begin
                obs_div++;
                if (obs_div1 < 0) obs_div1 = cyc;
            end
            if (done === 1'b1) obs_done = cyc;
        end
    end

    initial begin
        int fs;
        reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0; sum_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {ofifo_rd, acc, sum_out_valid, div, pmem_wr, busy, done,
                              sync_timeout}, 0);
        chk("reset_sfp_row", sfp_row, 0);
        chk("reset_pmem_add", pmem_add, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        fill(1, 1);
        do_pass(-1, 0);
        chk("nom_rd_count", obs_rd, 8);
        chk("nom_first_div", obs_div1, 11);
        chk("nom_wr_count", obs_wr, 8);
        chk("nom_done_cycle", obs_done, 27);

        fill(1, 1);
        ov[3] = 0; ov[4] = 0; ov[5] = 0;
        do_pass(-1, 0);
        chk("stall_rd_count", obs_rd, 8);
        chk("stall_acc_count", obs_acc, 8);
        chk("stall_done_cycle", obs_done, 30);

        fill(1, 0);
        siv[4] = 1;
        do_pass(-1, 0);
        chk("early_sync_len", obs_sov, 1);
        chk("early_first_div", obs_div1, 11);

        fill(1, 0);
        for (int t = 29; t < MAXC; t++) siv[t] = 1;
        do_pass(-1, 0);
        chk("late_sync_len", obs_sov, 20);
        chk("late_first_div", obs_div1, 30);
        chk("late_done_cycle", obs_done, 46);

        fill(1, 1);
        do_pass(15, 17);
        chk("abort_div_count", obs_div, 3);
        fill(1, 1);
        do_pass(-1, 0);
        chk("rerun_wr_count", obs_wr, 8);
        chk("rerun_done_cycle", obs_done, 27);

`ifdef SFP_SYNC_TIMEOUT_EN
        fill(1, 0);
        do_pass(-1, 0);
        chk("to_sync_len", obs_sov, TIMEOUT);
        chk("to_wr_count", obs_wr, 8);
        chk("to_flag_sticky", sync_timeout, 1);
        fill(1, 1);
        do_pass(-1, 0);
        chk("to_flag_cleared", sync_timeout, 0);
`endif

        for (int p = 0; p < 8; p++) begin
            fs = $urandom_range(1, 50);
            for (int t = 0; t < MAXC; t++) begin
                ov[t]  = (t >= 60) ? 1 : int'($urandom_range(0, 3) != 0);
                siv[t] = (t > fs) ? int'($urandom_range(0, 1)) : 0;
            end
            siv[fs] = 1;
            do_pass(-1, 0);
            chk("rand_wr_count", obs_wr, ROWS);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sfp_ctrl.md
Name: sfp_ctrl

Overview:
Sequencer for the SFP (softmax/normalisation) back-end that follows the OFIFO write phase of the core controller.
- Drains ROWS output rows from the OFIFO into the SFP accumulator.
- Exchanges the partial sum with the peer core through a valid-level handshake.
- Issues a per-row divide strobe, then writes each normalised row to PMEM.
- Starts from a pulse from the core controller and returns a one-cycle done pulse.

Parameters:
ROWS, 8, number of output rows per pass; must satisfy ROWS <= 2**ADDR_W
ADDR_W, 4, width of the row index and PMEM address
TIMEOUT, 64, SYNC wait limit in cycles; used only with SFP_SYNC_TIMEOUT_EN

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  pulse to begin a pass; ignored unless state is IDLE
ofifo_valid  in  1  OFIFO holds at least one row
ofifo_rd  out  1  OFIFO read strobe
acc  out  1  SFP accumulate strobe
sum_out_valid  out  1  local partial sum presented to the peer core
sum_in_valid  in  1  peer partial sum available (level)
div  out  1  SFP divide strobe for row sfp_row
sfp_row  out  ADDR_W  row index into the SFP row buffer
pmem_wr  out  1  PMEM write strobe
pmem_add  out  ADDR_W  PMEM write address
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of pass
sync_timeout  out  1  sticky flag: SYNC exited by timeout

Behaviour:
- Reset: state IDLE; every output 0; rd_cnt, row, peer_seen cleared. Reset mid-operation aborts the pass with no further strobes. Reset wins over a simultaneous start.
- States: IDLE, ACCUM, SYNC, DIV, WRITE, DONE.
- IDLE -> ACCUM on start.
- ACCUM:
  - ofifo_rd = ofifo_valid and rd_cnt < ROWS; rd_cnt increments on each ofifo_rd.
  - acc = ofifo_rd delayed one cycle, because OFIFO data is valid the cycle after the read.
  - ofifo_valid low stalls the phase with no strobes.
  - Exit to SYNC the cycle after the final acc, i.e. after rd_cnt == ROWS and the last acc has issued.
- peer_seen: sticky register set when sum_in_valid is high in ACCUM or SYNC; cleared in IDLE. A peer sum that arrives early is therefore never lost.
- SYNC:
  - sum_out_valid = 1 for the whole state.
  - Exit to DIV the cycle after (sum_in_valid or peer_seen) is sampled high, so the minimum SYNC duration is 1 cycle.
- DIV: div = 1, sfp_row = row. Next state is WRITE.
- WRITE: pmem_wr = 1, pmem_add = row.
  - If row == ROWS-1, go to DONE.
  - Otherwise row increments and state returns to DIV.
  - Each row takes exactly 2 cycles.
- DONE: done = 1 for one cycle, then IDLE. busy is low on the following cycle.
- Reference timing, ROWS=8, ofifo_valid and sum_in_valid held high, start at cycle 0:
  - ofifo_rd in cycles 1-8; acc in cycles 2-9.
  - sum_out_valid in cycle 10.
  - div in cycles 11,13,...,25; pmem_wr in cycles 12,14,...,26 with pmem_add 0..7.
  - done in cycle 27.
- sfp_row and pmem_add hold their last value outside DIV/WRITE and are 0 after reset.
- Counter widths: rd_cnt and row are sized ADDR_W+1 so that compares against ROWS do not wrap.

Optional Feature:
Macro SFP_SYNC_TIMEOUT_EN.
- Defined:
  - A counter runs in SYNC.
  - If neither sum_in_valid nor peer_seen is high for TIMEOUT consecutive SYNC cycles, exit to DIV.
  - On that exit, set sync_timeout; it stays set until reset or the next start.
  - The SFP then divides by the local sum only.
- Not defined:
  - SYNC waits indefinitely.
  - sync_timeout is tied to 0.
  - No counter logic is built.

Decomposition:
- Package sfp_ctrl_pkg holds:
  - the state encoding constants (IDLE=0 ... DONE=5, 3 bits);
  - the ROWS and ADDR_W defaults, so the core controller and the SFP datapath share them.
- One sub-module, sfp_sync_timer (load/enable/expire), instantiated only under SFP_SYNC_TIMEOUT_EN.
- The FSM and counters stay in sfp_ctrl.

Test Plan:
- Nominal, ROWS=8, inputs held high, start at cycle 0 -> exact strobe cycles listed above: 8 ofifo_rd, 8 acc, 8 div, 8 pmem_wr with addresses 0..7, done in cycle 27.
- ofifo_valid low in cycles 3-5 -> no ofifo_rd in those cycles; reads resume; total ofifo_rd = 8; each acc lags its read by exactly 1; done is delayed 3 cycles.
- sum_in_valid pulses once in cycle 4 (during ACCUM), low afterwards -> SYNC lasts 1 cycle; div first asserts the cycle after SYNC.
- sum_in_valid arrives 20 cycles into SYNC -> sum_out_valid stays high for 20 cycles, then DIV; no sync_timeout.
- Reset asserted in cycle 15 (mid-DIV) -> next cycle all outputs 0 and busy 0; a start 2 cycles later runs a clean full pass from row 0.
- Macro defined, TIMEOUT=64, sum_in_valid never asserted -> SYNC exits after 64 cycles; sync_timeout rises and stays high; all 8 pmem_wr still issue; start clears the flag.
